// File: rtl/rst_sequencer_pkg.sv
// Shared types and constants for the reset sequencer.
// Optional feature macro: RST_SEQUENCER_LOSS_CNT_EN (lock-loss counter).
package rst_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_HOLD,
        ST_WAIT,
        ST_REL,
        ST_RUN,
        ST_SW
    } state_t;

    localparam int LOSS_CNT_W = 8;

    localparam int N_RST_MIN  = 1;
    localparam int N_RST_MAX  = 16;
    localparam int N_LOCK_MIN = 1;
    localparam int N_LOCK_MAX = 8;

    // True when every parameter is in range and the delay counter is wide enough.
    function automatic bit params_ok(input int n_rst, input int n_lock, input int stage_dly,
                                     input int filt_len, input int sw_hold, input int dly_w);
        longint lim;
        lim = longint'(1) << dly_w;
        params_ok = (n_rst >= N_RST_MIN) && (n_rst <= N_RST_MAX) &&
                    (n_lock >= N_LOCK_MIN) && (n_lock <= N_LOCK_MAX) &&
                    (stage_dly >= 1) && (filt_len >= 1) && (sw_hold >= 1) &&
                    (dly_w >= 1) && (dly_w <= 31) &&
                    (longint'(stage_dly) < lim) && (longint'(filt_len) < lim) &&
                    (longint'(sw_hold) < lim);
    endfunction

endpackage

// File: rtl/rst_sequencer_lock_filt.sv
// Lock-flag conditioning: two-flop synchroniser per lock bit followed by a
// debounce counter. lock_ok_o rises after FILT_LEN consecutive cycles with all
// synced bits high and drops in the same cycle any synced bit goes low.
module rst_sequencer_lock_filt
    import rst_sequencer_pkg::*;
#(
    parameter int N_LOCK   = 2,
    parameter int FILT_LEN = 4,
    parameter int DLY_W    = 16
) (
    input  logic              wb_clk_i,
    input  logic              rst_n_i,
    input  logic [N_LOCK-1:0] lock_i,
    output logic              lock_ok_o
);

    localparam logic [DLY_W-1:0] FILT_MAX = DLY_W'(FILT_LEN);

    logic [N_LOCK-1:0] r_sync1;
    logic [N_LOCK-1:0] r_sync2;
    logic [DLY_W-1:0]  r_cnt;
    logic              w_all_hi;

    // Bring the asynchronous lock flags into the wishbone clock domain.
    always_ff @(posedge wb_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= lock_i;
            r_sync2 <= r_sync1;
        end
    end

    assign w_all_hi = &r_sync2;

    // Count consecutive all-locked cycles, saturating at FILT_LEN; any drop restarts.
    always_ff @(posedge wb_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_cnt <= '0;
        end else if (!w_all_hi) begin
            r_cnt <= '0;
        end else if (r_cnt < FILT_MAX) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign lock_ok_o = w_all_hi && (r_cnt == FILT_MAX);

endmodule

// File: rtl/rst_sequencer.sv
// Reset sequencer for the clock tree: holds all domain resets until the lock
// flags are stable, releases them one by one in ascending order with
// STAGE_DLY spacing, and re-asserts everything on lock loss or software request.
// Optional feature macro: RST_SEQUENCER_LOSS_CNT_EN enables the saturating
// lock-loss counter on loss_cnt_o; otherwise loss_cnt_o is tied to zero.
module rst_sequencer
    import rst_sequencer_pkg::*;
#(
    parameter int N_RST     = 4,
    parameter int N_LOCK    = 2,
    parameter int STAGE_DLY = 16,
    parameter int FILT_LEN  = 4,
    parameter int SW_HOLD   = 8,
    parameter int DLY_W     = 16
) (
    input  logic                  wb_clk_i,
    input  logic                  rst_n_i,
    input  logic [N_LOCK-1:0]     lock_i,
    input  logic                  sw_rst_i,
    output logic [N_RST-1:0]      rst_o,
    output logic                  all_rdy_o,
    output logic                  lock_lost_o,
    output logic [LOSS_CNT_W-1:0] loss_cnt_o
);

    localparam int               K_W          = $clog2(N_RST + 1);
    localparam logic [K_W-1:0]   K_DONE       = K_W'(N_RST);
    localparam logic [DLY_W-1:0] STAGE_RELOAD = DLY_W'(STAGE_DLY - 1);
    localparam logic [DLY_W-1:0] SW_RELOAD    = DLY_W'(SW_HOLD - 1);

    if (!params_ok(N_RST, N_LOCK, STAGE_DLY, FILT_LEN, SW_HOLD, DLY_W)) begin : g_param_chk
        $error("rst_sequencer: parameter out of range");
    end

    state_t           r_state, w_state_nxt;
    logic [DLY_W-1:0] r_cnt, w_cnt_nxt;
    logic [K_W-1:0]   r_k, w_k_nxt;
    logic [N_RST-1:0] r_rst, w_rst_nxt;
    logic             r_lock_lost, w_lock_lost_nxt;
    logic             r_run_seen, w_run_seen_nxt;
    logic             w_lock_ok;
    logic             w_lock_drop;
    logic             w_sw_take;

    rst_sequencer_lock_filt #(
        .N_LOCK   (N_LOCK),
        .FILT_LEN (FILT_LEN),
        .DLY_W    (DLY_W)
    ) u_lock_filt (
        .wb_clk_i  (wb_clk_i),
        .rst_n_i   (rst_n_i),
        .lock_i    (lock_i),
        .lock_ok_o (w_lock_ok)
    );

    // Lock loss only matters once sequencing has started; it takes priority over software.
    assign w_lock_drop = !w_lock_ok && (r_state inside {ST_REL, ST_RUN, ST_SW});
    assign w_sw_take   = sw_rst_i && !w_lock_drop && (r_state inside {ST_WAIT, ST_REL, ST_RUN});

    // State, counters and registered outputs; reset forces all domain resets on.
    always_ff @(posedge wb_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state     <= ST_HOLD;
            r_cnt       <= '0;
            r_k         <= '0;
            r_rst       <= '1;
            r_lock_lost <= 1'b0;
            r_run_seen  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_k         <= w_k_nxt;
            r_rst       <= w_rst_nxt;
            r_lock_lost <= w_lock_lost_nxt;
            r_run_seen  <= w_run_seen_nxt;
        end
    end

    // Next-state logic: lock loss, then software request, then the normal sequence.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_k_nxt         = r_k;
        w_rst_nxt       = r_rst;
        w_lock_lost_nxt = r_lock_lost;
        w_run_seen_nxt  = r_run_seen;
        if (w_lock_drop) begin
            w_state_nxt = ST_HOLD;
            w_rst_nxt   = '1;
            if (r_run_seen) begin
                w_lock_lost_nxt = 1'b1;
            end
        end else if (w_sw_take) begin
            w_state_nxt     = ST_SW;
            w_rst_nxt       = '1;
            w_cnt_nxt       = SW_RELOAD;
            w_lock_lost_nxt = 1'b0;
            w_run_seen_nxt  = 1'b0;
        end else begin
            case (r_state)
                ST_HOLD: begin
                    w_rst_nxt   = '1;
                    w_state_nxt = ST_WAIT;
                end
                ST_WAIT: begin
                    w_rst_nxt = '1;
                    if (w_lock_ok) begin
                        w_state_nxt = ST_REL;
                        w_k_nxt     = '0;
                        w_cnt_nxt   = STAGE_RELOAD;
                    end
                end
                ST_REL: begin
                    if (r_k == K_DONE) begin
                        w_state_nxt    = ST_RUN;
                        w_run_seen_nxt = 1'b1;
                    end else if (r_cnt == '0) begin
                        for (int i = 0; i < N_RST; i++) begin
                            if (K_W'(i) == r_k) begin
                                w_rst_nxt[i] = 1'b0;
                            end
                        end
                        w_k_nxt   = r_k + 1'b1;
                        w_cnt_nxt = STAGE_RELOAD;
                    end else begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end
                end
                ST_RUN: begin
                    w_rst_nxt = '0;
                end
                ST_SW: begin
                    w_rst_nxt = '1;
                    if (r_cnt == '0) begin
                        w_state_nxt = ST_HOLD;
                    end else begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_HOLD;
                    w_rst_nxt   = '1;
                end
            endcase
        end
    end

    assign rst_o       = r_rst;
    assign all_rdy_o   = (r_state == ST_RUN);
    assign lock_lost_o = r_lock_lost;

`ifdef RST_SEQUENCER_LOSS_CNT_EN
    logic [LOSS_CNT_W-1:0] r_loss_cnt;

    // Count lock-loss entries into HOLD, saturating; an accepted software reset clears it.
    always_ff @(posedge wb_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_loss_cnt <= '0;
        end else if (w_sw_take) begin
            r_loss_cnt <= '0;
        end else if (w_lock_drop && (r_loss_cnt != '1)) begin
            r_loss_cnt <= r_loss_cnt + 1'b1;
        end
    end

    assign loss_cnt_o = r_loss_cnt;
`else
    assign loss_cnt_o = '0;
`endif

endmodule

// File: tb/tb_rst_sequencer.sv
// Directed bench for rst_sequencer with default parameters. Edge numbers in
// the sequences below count rising edges from a local origin; inputs change
// and outputs are sampled 1 ns after the numbered edge.
module tb_rst_sequencer;

`ifdef RST_SEQUENCER_LOSS_CNT_EN
    localparam logic [31:0] LC_ONE = 32'd1;
`else
    localparam logic [31:0] LC_ONE = 32'd0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] lock;
    logic       sw;
    logic [3:0] rst_o;
    logic       all_rdy;
    logic       lock_lost;
    logic [7:0] loss_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int ed      = 0;

    always #5 clk = ~clk;

    rst_sequencer #(
        .N_RST     (4),
        .N_LOCK    (2),
        .STAGE_DLY (16),
        .FILT_LEN  (4),
        .SW_HOLD   (8),
        .DLY_W     (16)
    ) dut (
        .wb_clk_i    (clk),
        .rst_n_i     (rst_n),
        .lock_i      (lock),
        .sw_rst_i    (sw),
        .rst_o       (rst_o),
        .all_rdy_o   (all_rdy),
        .lock_lost_o (lock_lost),
        .loss_cnt_o  (loss_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step_to(input int e);
        while (ed < e) begin
            @(posedge clk);
            #1;
            ed++;
        end
    endtask

    initial begin
        // reset state
        rst_n = 1'b0;
        lock  = 2'b00;
        sw    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rst_o", rst_o, 32'hF);
        chk("rst_all_rdy", all_rdy, 0);
        chk("rst_lock_lost", lock_lost, 0);
        chk("rst_loss_cnt", loss_cnt, 0);

        // cold start
        @(negedge clk);
        rst_n = 1'b1;
        ed = -1;
        step_to(0);
        lock = 2'b11;
        chk("cold_e0", rst_o, 32'hF);
        step_to(22); chk("cold_e22", rst_o, 32'hF);
        step_to(23); chk("cold_e23", rst_o, 32'hE);
        step_to(38); chk("cold_e38", rst_o, 32'hE);
        step_to(39); chk("cold_e39", rst_o, 32'hC);
        step_to(55); chk("cold_e55", rst_o, 32'h8);
        step_to(70); chk("cold_e70", rst_o, 32'h8);
        step_to(71); chk("cold_e71", rst_o, 32'h0);
        chk("cold_rdy_e71", all_rdy, 0);
        step_to(72); chk("cold_rdy_e72", all_rdy, 1);

        // lock loss in RUN
        ed = 0;
        lock = 2'b10;
        step_to(2);
        chk("loss_e2_rst", rst_o, 32'h0);
        chk("loss_e2_rdy", all_rdy, 1);
        step_to(3);
        chk("loss_e3_rst", rst_o, 32'hF);
        chk("loss_e3_rdy", all_rdy, 0);
        chk("loss_e3_lost", lock_lost, 1);
        chk("loss_e3_cnt", loss_cnt, LC_ONE);

        // re-lock, then software reset when rst_o = 1100
        ed = 0;
        lock = 2'b11;
        step_to(39); chk("resq_e39", rst_o, 32'hC);
        step_to(40);
        sw = 1'b1;
        chk("sw_e40", rst_o, 32'hC);
        step_to(41);
        sw = 1'b0;
        chk("sw_e41_rst", rst_o, 32'hF);
        chk("sw_e41_rdy", all_rdy, 0);
        chk("sw_e41_lost", lock_lost, 0);
        chk("sw_e41_cnt", loss_cnt, 0);
        step_to(48); chk("sw_e48", rst_o, 32'hF);
        step_to(66); chk("sw_e66", rst_o, 32'hF);
        step_to(67); chk("sw_e67", rst_o, 32'hE);
        step_to(83); chk("sw_e83", rst_o, 32'hC);
        step_to(99); chk("sw_e99", rst_o, 32'h8);
        step_to(115); chk("sw_e115", rst_o, 32'h0);
        chk("sw_rdy_e115", all_rdy, 0);
        step_to(116); chk("sw_rdy_e116", all_rdy, 1);

        // simultaneous software request and lock loss
        ed = 0;
        lock = 2'b01;
        step_to(2);
        sw = 1'b1;
        chk("sim_e2_rdy", all_rdy, 1);
        step_to(3);
        sw = 1'b0;
        chk("sim_e3_rst", rst_o, 32'hF);
        chk("sim_e3_rdy", all_rdy, 0);
        chk("sim_e3_lost", lock_lost, 1);
        chk("sim_e3_cnt", loss_cnt, LC_ONE);

        // one-cycle glitch on lock_i[1] during WAIT
        ed = 0;
        lock = 2'b11;
        step_to(3);
        lock = 2'b01;
        step_to(4);
        lock = 2'b11;
        step_to(10); chk("glitch_e10", rst_o, 32'hF);
        step_to(23); chk("glitch_e23", rst_o, 32'hF);
        step_to(26); chk("glitch_e26", rst_o, 32'hF);
        chk("glitch_lost", lock_lost, 1);
        step_to(27); chk("glitch_e27", rst_o, 32'hE);

        // asynchronous reset pulse mid-release
        step_to(30);
        chk("arst_pre", rst_o, 32'hE);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_rst_o", rst_o, 32'hF);
        chk("arst_rdy", all_rdy, 0);
        chk("arst_lost", lock_lost, 0);
        chk("arst_cnt", loss_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ed = -1;
        step_to(0);  chk("arst_e0", rst_o, 32'hF);
        step_to(21); chk("arst_e21", rst_o, 32'hF);
        step_to(22); chk("arst_e22", rst_o, 32'hE);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
